// File: rtl/polara_loopback_rx.sv
// polara_loopback_rx
// -------------------
// Chipset-side receiver and checker for the three chip-to-chipset NoC links.
// One link, chosen by the debounced switch, is accepted with a val/rdy
// handshake. Each packet header is parsed and checked against the expected
// CHIPID, FBITS and message type. The payload flits are then consumed
// without being checked or stored. Saturating counters and a sticky error
// flag are exposed for the block design and the ILA.
//
// Ports:
//   chipset_clk                 sole clock
//   chipset_rst_n               synchronous, active-low reset
//   rx_en                       enables acceptance (0 forces every rdy low)
//   sw_channel                  link select: 1..3 = noc1..3, 0 = none
//   cnt_clr                     synchronous clear of counters and err_sticky
//   intf_chipset_data_nocN      flit data from the chip
//   intf_chipset_val_nocN       flit valid from the chip
//   intf_chipset_rdy_nocN       flit accept back to the chip
//   pkt_count                   completed packets
//   flit_count                  accepted flits (header and payload)
//   err_count                   headers with at least one field mismatch
//   err_sticky                  set on the first mismatch, held until cleared
//   last_header                 most recently accepted header flit
//   pkt_done                    one-cycle pulse after a packet completes
//   busy                        high while payload flits are outstanding

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

`ifndef MSG_TYPE_INV_FWD
`define MSG_TYPE_INV_FWD 8'd18
`endif

module polara_loopback_rx #(
  parameter logic [13:0] EXP_CHIPID   = 14'b10000000000000,
  parameter logic [3:0]  EXP_FBITS    = 4'b0010,
  parameter logic [7:0]  EXP_MSG_TYPE = `MSG_TYPE_INV_FWD,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                       chipset_clk,
  input  logic                       chipset_rst_n,
  input  logic                       rx_en,
  input  logic [1:0]                 sw_channel,
  input  logic                       cnt_clr,
  input  logic [`NOC_DATA_WIDTH-1:0] intf_chipset_data_noc1,
  input  logic [`NOC_DATA_WIDTH-1:0] intf_chipset_data_noc2,
  input  logic [`NOC_DATA_WIDTH-1:0] intf_chipset_data_noc3,
  input  logic                       intf_chipset_val_noc1,
  input  logic                       intf_chipset_val_noc2,
  input  logic                       intf_chipset_val_noc3,
  output logic                       intf_chipset_rdy_noc1,
  output logic                       intf_chipset_rdy_noc2,
  output logic                       intf_chipset_rdy_noc3,
  output logic [CNT_WIDTH-1:0]       pkt_count,
  output logic [CNT_WIDTH-1:0]       flit_count,
  output logic [CNT_WIDTH-1:0]       err_count,
  output logic                       err_sticky,
  output logic [`NOC_DATA_WIDTH-1:0] last_header,
  output logic                       pkt_done,
  output logic                       busy
);

  typedef enum logic {
    ST_IDLE,
    ST_BODY
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state_q, state_d;
  logic [1:0]                 cur_ch_q, cur_ch_d;
  logic [7:0]                 remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]       pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0]       flit_count_q, flit_count_d;
  logic [CNT_WIDTH-1:0]       err_count_q, err_count_d;
  logic                       err_sticky_q, err_sticky_d;
  logic [`NOC_DATA_WIDTH-1:0] last_header_q, last_header_d;
  logic                       pkt_done_q, pkt_done_d;

  logic                       val_sel;
  logic                       rdy_sel;
  logic [`NOC_DATA_WIDTH-1:0] data_sel;
  logic                       hs;
  logic                       hdr_err;
  logic [7:0]                 hdr_len;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // rdy depends only on registered cur_ch, rx_en and the reset input, so
  // there is never a combinational path from val to rdy. rdy is held low
  // during a reset cycle so that no flit is accepted while reset is asserted.
  assign intf_chipset_rdy_noc1 = rx_en & (cur_ch_q == 2'd1) & chipset_rst_n;
  assign intf_chipset_rdy_noc2 = rx_en & (cur_ch_q == 2'd2) & chipset_rst_n;
  assign intf_chipset_rdy_noc3 = rx_en & (cur_ch_q == 2'd3) & chipset_rst_n;

  // Mux the val, rdy and data of the latched channel. Channel 0 selects
  // nothing, so no handshake can occur.
  always_comb begin
    val_sel  = 1'b0;
    rdy_sel  = 1'b0;
    data_sel = '0;
    case (cur_ch_q)
      2'd1: begin
        val_sel  = intf_chipset_val_noc1;
        rdy_sel  = intf_chipset_rdy_noc1;
        data_sel = intf_chipset_data_noc1;
      end
      2'd2: begin
        val_sel  = intf_chipset_val_noc2;
        rdy_sel  = intf_chipset_rdy_noc2;
        data_sel = intf_chipset_data_noc2;
      end
      2'd3: begin
        val_sel  = intf_chipset_val_noc3;
        rdy_sel  = intf_chipset_rdy_noc3;
        data_sel = intf_chipset_data_noc3;
      end
      default: begin
        val_sel  = 1'b0;
        rdy_sel  = 1'b0;
        data_sel = '0;
      end
    endcase
  end

  assign hs      = val_sel & rdy_sel;
  assign hdr_len = data_sel[29:22];
  assign hdr_err = (data_sel[63:50] != EXP_CHIPID) |
                   (data_sel[33:30] != EXP_FBITS)  |
                   (data_sel[21:14] != EXP_MSG_TYPE);

  // Next-state logic for the packet FSM, the channel latch and the counters.
  // The channel follows the switch only on IDLE cycles without a handshake.
  // That keeps it frozen from the header until the final payload flit. A
  // counter clear is applied last, so it overrides any increment in the
  // same cycle but leaves the FSM, remaining and cur_ch alone.
  always_comb begin
    state_d       = state_q;
    cur_ch_d      = cur_ch_q;
    remaining_d   = remaining_q;
    pkt_count_d   = pkt_count_q;
    flit_count_d  = flit_count_q;
    err_count_d   = err_count_q;
    err_sticky_d  = err_sticky_q;
    last_header_d = last_header_q;
    pkt_done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          last_header_d = data_sel;
          remaining_d   = hdr_len;
          if (hdr_err) begin
            err_count_d  = sat_inc(err_count_q);
            err_sticky_d = 1'b1;
          end
          if (hdr_len == 8'd0) begin
            pkt_count_d = sat_inc(pkt_count_q);
            pkt_done_d  = 1'b1;
          end else begin
            state_d = ST_BODY;
          end
        end else begin
          cur_ch_d = sw_channel;
        end
      end
      ST_BODY: begin
        if (hs) begin
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            pkt_count_d = sat_inc(pkt_count_q);
            pkt_done_d  = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hs) begin
      flit_count_d = sat_inc(flit_count_q);
    end

    if (cnt_clr) begin
      pkt_count_d  = '0;
      flit_count_d = '0;
      err_count_d  = '0;
      err_sticky_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset. A reset in the middle
  // of a packet drops it silently, and the next accepted flit is a header.
  always_ff @(posedge chipset_clk) begin
    if (!chipset_rst_n) begin
      state_q       <= ST_IDLE;
      cur_ch_q      <= 2'd0;
      remaining_q   <= 8'd0;
      pkt_count_q   <= '0;
      flit_count_q  <= '0;
      err_count_q   <= '0;
      err_sticky_q  <= 1'b0;
      last_header_q <= '0;
      pkt_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_ch_q      <= cur_ch_d;
      remaining_q   <= remaining_d;
      pkt_count_q   <= pkt_count_d;
      flit_count_q  <= flit_count_d;
      err_count_q   <= err_count_d;
      err_sticky_q  <= err_sticky_d;
      last_header_q <= last_header_d;
      pkt_done_q    <= pkt_done_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign flit_count  = flit_count_q;
  assign err_count   = err_count_q;
  assign err_sticky  = err_sticky_q;
  assign last_header = last_header_q;
  assign pkt_done    = pkt_done_q;
  assign busy        = (state_q == ST_BODY);

endmodule

// File: tb/tb_polara_loopback_rx.sv
// Testbench for polara_loopback_rx. It runs directed scenarios first and
// then randomized traffic. A packet-level reference model tracks the
// outputs on every cycle, and hand-computed literal checks pin key points
// of the directed run.

module tb_polara_loopback_rx;

   localparam int           CW       = 8;
   localparam logic [13:0]  EXP_CHIP = 14'b10000000000000;
   localparam logic [3:0]   EXP_FB   = 4'b0010;
   localparam logic [7:0]   EXP_MSG  = 8'd18;
   localparam int           MAXC     = (1 << CW) - 1;

   logic             clk;
   logic             rstN;
   logic             rxEn;
   logic [1:0]       sw;
   logic             cntClr;
   logic [63:0]      dataNoc [1:3];
   logic             valNoc [1:3];
   logic             rdy1, rdy2, rdy3;
   logic [CW-1:0]    pktCount, flitCount, errCount;
   logic             errSticky;
   logic [63:0]      lastHeader;
   logic             pktDone;
   logic             busy;

   int checkCount = 0;
   int passCount  = 0;
   bit checkEn    = 0;

   // Model state: the number of payload flits still owed, the latched
   // channel and plain integer counters that saturate at MAXC.
   int          mPkt, mFlit, mErr, mLeft;
   logic [1:0]  mChan;
   logic        mSticky, mDone;
   logic [63:0] mHdr;

   polara_loopback_rx #(
      .EXP_CHIPID   (EXP_CHIP),
      .EXP_FBITS    (EXP_FB),
      .EXP_MSG_TYPE (EXP_MSG),
      .CNT_WIDTH    (CW)
   ) dut (
      .chipset_clk            (clk),
      .chipset_rst_n          (rstN),
      .rx_en                  (rxEn),
      .sw_channel             (sw),
      .cnt_clr                (cntClr),
      .intf_chipset_data_noc1 (dataNoc[1]),
      .intf_chipset_data_noc2 (dataNoc[2]),
      .intf_chipset_data_noc3 (dataNoc[3]),
      .intf_chipset_val_noc1  (valNoc[1]),
      .intf_chipset_val_noc2  (valNoc[2]),
      .intf_chipset_val_noc3  (valNoc[3]),
      .intf_chipset_rdy_noc1  (rdy1),
      .intf_chipset_rdy_noc2  (rdy2),
      .intf_chipset_rdy_noc3  (rdy3),
      .pkt_count              (pktCount),
      .flit_count             (flitCount),
      .err_count              (errCount),
      .err_sticky             (errSticky),
      .last_header            (lastHeader),
      .pkt_done               (pktDone),
      .busy                   (busy)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] makeHeader(input logic [13:0] chip, input logic [3:0] fb,
                                              input logic [7:0] len, input logic [7:0] msg);
      logic [63:0] h;
      h = {$urandom, $urandom};
      h[63:50] = chip;
      h[33:30] = fb;
      h[29:22] = len;
      h[21:14] = msg;
      return h;
   endfunction

   function automatic logic [63:0] randFlit();
      if ($urandom_range(0, 9) < 7) begin
         return makeHeader(EXP_CHIP, EXP_FB, 8'($urandom_range(0, 3)), EXP_MSG);
      end
      return makeHeader(14'($urandom), 4'($urandom), 8'($urandom_range(0, 3)), 8'($urandom));
   endfunction

   // Reference model. A packet is a header followed by exactly `length`
   // payload flits, and mLeft counts the payload flits still owed. The
   // channel follows the switch whenever nothing is owed and no flit moves.
   always @(posedge clk) begin
      int          pkt, flit, err, left;
      logic [1:0]  ch;
      logic        st, done, hs;
      logic [63:0] hdr, d;
      pkt = mPkt; flit = mFlit; err = mErr; left = mLeft;
      ch = mChan; st = mSticky; hdr = mHdr; done = 1'b0;
      if (!rstN) begin
         pkt = 0; flit = 0; err = 0; left = 0; ch = 2'd0; st = 1'b0; hdr = '0;
      end else begin
         hs = 1'b0;
         d  = '0;
         if (ch != 2'd0) begin
            hs = rxEn && valNoc[int'(ch)];
            d  = dataNoc[int'(ch)];
         end
         if (hs) begin
            if (flit < MAXC) flit++;
            if (left == 0) begin
               hdr = d;
               if (d[63:50] != EXP_CHIP || d[33:30] != EXP_FB || d[21:14] != EXP_MSG) begin
                  if (err < MAXC) err++;
                  st = 1'b1;
               end
               left = int'(d[29:22]);
               if (left == 0) begin
                  if (pkt < MAXC) pkt++;
                  done = 1'b1;
               end
            end else begin
               left--;
               if (left == 0) begin
                  if (pkt < MAXC) pkt++;
                  done = 1'b1;
               end
            end
         end else if (left == 0) begin
            ch = sw;
         end
         if (cntClr) begin
            pkt = 0; flit = 0; err = 0; st = 1'b0;
         end
      end
      mPkt <= pkt; mFlit <= flit; mErr <= err; mLeft <= left;
      mChan <= ch; mSticky <= st; mHdr <= hdr; mDone <= done;
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("pkt_count", 64'(pktCount), 64'(mPkt));
         checkOutput("flit_count", 64'(flitCount), 64'(mFlit));
         checkOutput("err_count", 64'(errCount), 64'(mErr));
         checkOutput("err_sticky", 64'(errSticky), 64'(mSticky));
         checkOutput("last_header", lastHeader, mHdr);
         checkOutput("pkt_done", 64'(pktDone), 64'(mDone));
         checkOutput("busy", 64'(busy), 64'(mLeft != 0));
         checkOutput("rdy_noc1", 64'(rdy1), 64'(rxEn && rstN && mChan == 2'd1));
         checkOutput("rdy_noc2", 64'(rdy2), 64'(rxEn && rstN && mChan == 2'd2));
         checkOutput("rdy_noc3", 64'(rdy3), 64'(rxEn && rstN && mChan == 2'd3));
      end
   end

   // Present one flit on a channel for exactly one clock edge.
   task automatic sendFlit(input int ch, input logic [63:0] d);
      dataNoc[ch] = d;
      valNoc[ch]  = 1'b1;
      @(posedge clk);
      #1;
      valNoc[ch]  = 1'b0;
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
   endtask

   // One cycle of random traffic on all three links plus control noise.
   task automatic applyStimulus();
      for (int c = 1; c <= 3; c++) begin
         valNoc[c]  = ($urandom_range(0, 9) < 6);
         dataNoc[c] = randFlit();
      end
      if ($urandom_range(0, 19) == 0) sw = 2'($urandom_range(0, 3));
      rxEn   = ($urandom_range(0, 9) != 0);
      cntClr = ($urandom_range(0, 49) == 0);
      rstN   = ($urandom_range(0, 199) != 0);
   endtask

   initial begin
      logic [63:0] h;
      rstN = 1'b0; rxEn = 1'b0; sw = 2'd0; cntClr = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         valNoc[c]  = 1'b0;
         dataNoc[c] = '0;
      end

      // Reset state.
      repeat (3) @(posedge clk);
      checkEn = 1;
      @(negedge clk);
      checkOutput("reset pkt_count", 64'(pktCount), 64'd0);
      checkOutput("reset last_header", lastHeader, 64'd0);
      checkOutput("reset rdy_noc2", 64'(rdy2), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);

      // Single zero-length matching header on noc2.
      @(posedge clk); #1;
      rstN = 1'b1; sw = 2'd2; rxEn = 1'b1;
      idleCycle();
      h = makeHeader(EXP_CHIP, EXP_FB, 8'd0, EXP_MSG);
      dataNoc[2] = h;
      valNoc[2]  = 1'b1;
      @(negedge clk);
      checkOutput("lit rdy_noc2", 64'(rdy2), 64'd1);
      checkOutput("lit rdy_noc1", 64'(rdy1), 64'd0);
      checkOutput("lit rdy_noc3", 64'(rdy3), 64'd0);
      @(posedge clk); #1;
      valNoc[2] = 1'b0;
      @(negedge clk);
      checkOutput("lit pkt_count 1", 64'(pktCount), 64'd1);
      checkOutput("lit flit_count 1", 64'(flitCount), 64'd1);
      checkOutput("lit err_count 0", 64'(errCount), 64'd0);
      checkOutput("lit pkt_done high", 64'(pktDone), 64'd1);
      checkOutput("lit last_header", lastHeader, h);
      @(negedge clk);
      checkOutput("lit pkt_done low", 64'(pktDone), 64'd0);

      // Length-3 packet with two idle cycles between flits.
      idleCycle();
      sendFlit(2, makeHeader(EXP_CHIP, EXP_FB, 8'd3, EXP_MSG));
      @(negedge clk);
      checkOutput("lit busy after header", 64'(busy), 64'd1);
      for (int k = 0; k < 3; k++) begin
         repeat (2) idleCycle();
         sendFlit(2, {$urandom, $urandom});
         @(negedge clk);
         if (k < 2) begin
            checkOutput("lit busy mid body", 64'(busy), 64'd1);
            checkOutput("lit no early pkt_done", 64'(pktDone), 64'd0);
         end
      end
      checkOutput("lit pkt_count 2", 64'(pktCount), 64'd2);
      checkOutput("lit flit_count 5", 64'(flitCount), 64'd5);
      checkOutput("lit pkt_done body", 64'(pktDone), 64'd1);
      checkOutput("lit busy end", 64'(busy), 64'd0);

      // Mismatching header, then a matching one.
      idleCycle();
      sendFlit(2, makeHeader(14'd0, EXP_FB, 8'd0, 8'd0));
      @(negedge clk);
      checkOutput("lit err_count 1", 64'(errCount), 64'd1);
      checkOutput("lit err_sticky", 64'(errSticky), 64'd1);
      checkOutput("lit pkt_count 3", 64'(pktCount), 64'd3);
      idleCycle();
      sendFlit(2, makeHeader(EXP_CHIP, EXP_FB, 8'd0, EXP_MSG));
      @(negedge clk);
      checkOutput("lit err_count held", 64'(errCount), 64'd1);

      // Switch change during a length-2 packet.
      idleCycle();
      sendFlit(2, makeHeader(EXP_CHIP, EXP_FB, 8'd2, EXP_MSG));
      sw = 2'd3;
      valNoc[3]  = 1'b1;
      dataNoc[3] = makeHeader(EXP_CHIP, EXP_FB, 8'd0, EXP_MSG);
      idleCycle();
      @(negedge clk);
      checkOutput("lit rdy stays noc2", 64'(rdy2), 64'd1);
      checkOutput("lit noc3 not ready", 64'(rdy3), 64'd0);
      @(posedge clk); #1;
      sendFlit(2, {$urandom, $urandom});
      sendFlit(2, {$urandom, $urandom});
      @(negedge clk);
      checkOutput("lit rdy noc2 idle cycle", 64'(rdy2), 64'd1);
      checkOutput("lit rdy noc3 not yet", 64'(rdy3), 64'd0);
      valNoc[3] = 1'b0;
      @(negedge clk);
      checkOutput("lit rdy moved noc3", 64'(rdy3), 64'd1);
      checkOutput("lit rdy noc2 off", 64'(rdy2), 64'd0);
      checkOutput("lit pkt_count 5", 64'(pktCount), 64'd5);
      checkOutput("lit flit_count 10", 64'(flitCount), 64'd10);

      // Reset after one of four payload flits.
      @(posedge clk); #1;
      sendFlit(3, makeHeader(EXP_CHIP, EXP_FB, 8'd4, EXP_MSG));
      sendFlit(3, {$urandom, $urandom});
      rstN = 1'b0;
      @(posedge clk); #1;
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("lit rst pkt_count", 64'(pktCount), 64'd0);
      checkOutput("lit rst flit_count", 64'(flitCount), 64'd0);
      checkOutput("lit rst busy", 64'(busy), 64'd0);
      checkOutput("lit rst rdy_noc3", 64'(rdy3), 64'd0);
      idleCycle();
      h = makeHeader(EXP_CHIP, EXP_FB, 8'd0, EXP_MSG);
      sendFlit(3, h);
      @(negedge clk);
      checkOutput("lit post-rst header", lastHeader, h);
      checkOutput("lit post-rst pkt_count", 64'(pktCount), 64'd1);

      // Counter clear coinciding with a completing handshake.
      @(posedge clk); #1;
      cntClr = 1'b1;
      sendFlit(3, makeHeader(EXP_CHIP, EXP_FB, 8'd0, EXP_MSG));
      cntClr = 1'b0;
      @(negedge clk);
      checkOutput("lit clr pkt_count", 64'(pktCount), 64'd0);
      checkOutput("lit clr flit_count", 64'(flitCount), 64'd0);
      @(posedge clk); #1;
      sendFlit(3, makeHeader(EXP_CHIP, EXP_FB, 8'd0, EXP_MSG));
      @(negedge clk);
      checkOutput("lit after clr pkt_count", 64'(pktCount), 64'd1);

      // Back-to-back zero-length packets until the counters saturate.
      @(posedge clk); #1;
      dataNoc[3] = makeHeader(EXP_CHIP, EXP_FB, 8'd0, EXP_MSG);
      valNoc[3]  = 1'b1;
      repeat ((1 << CW) + 2) @(posedge clk);
      #1;
      valNoc[3] = 1'b0;
      @(negedge clk);
      checkOutput("lit pkt_count saturated", 64'(pktCount), 64'(MAXC));
      checkOutput("lit flit_count saturated", 64'(flitCount), 64'(MAXC));

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         applyStimulus();
         @(posedge clk); #1;
      end
      rstN = 1'b1;
      for (int c = 1; c <= 3; c++) valNoc[c] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkEn = 0;

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
